// File: rtl/frontend_pkg.sv
// Shared types for the fetch-to-decode issue window.
//   slot_t     : one buffered instruction with its pre-decoded traits and masks
//   sel_rule_e : which selection rule picked the current emission
//   reg_bit    : one-hot register mask for GPRs 1..31 (r0 carries no dependency)
//   dep_any    : RAW/WAR/WAW overlap test between two mask pairs
package frontend_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = 31;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic              is_lw;
    logic              is_sw;
    logic              is_branch;
    logic              is_jtype;
  } slot_t;

  typedef enum logic [2:0] {
    SEL_BRANCH_HEAD,
    SEL_DROP_NOP,
    SEL_HOIST_BR,
    SEL_HOIST_LW,
    SEL_HEAD
  } sel_rule_e;

  // Bit r-1 stands for register r; r0 never creates a hazard.
  function automatic logic [MASK_W-1:0] reg_bit(input logic [4:0] r);
    reg_bit = (r == 5'd0) ? '0 : (MASK_W'(1) << (r - 5'd1));
  endfunction

  // Nonzero when either side writes something the other reads or writes.
  function automatic logic dep_any(input logic [MASK_W-1:0] ar, input logic [MASK_W-1:0] aw,
                                   input logic [MASK_W-1:0] br, input logic [MASK_W-1:0] bw);
    dep_any = |((aw & (br | bw)) | (bw & (ar | aw)));
  endfunction

endpackage

// File: rtl/frontend_issue_window_if.sv
// Fetch/decode handshake bundle of the issue window.
//   master : fetch + decode side (drives in_*, out_ready, flush)
//   slave  : the issue window (drives in_ready, out_valid, pc, instr, pred_pc,
//            hoisted, hoist_count)
interface frontend_issue_window_if;
  import frontend_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pred_pc;
  logic            hoisted;
  logic            flush;
  logic [XLEN-1:0] hoist_count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, pc, instr, pred_pc, hoisted, hoist_count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, pc, instr, pred_pc, hoisted, hoist_count
  );

endinterface

// File: rtl/fiw_entry_decode.sv
// Enqueue-path decoder: turns a fetched {pc, instr} into a window slot with
// MIPS instruction traits and register read/write masks.
//   i_pc, i_instr : fetched address and word
//   o_slot        : decoded slot payload
module fiw_entry_decode
  import frontend_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  output slot_t           o_slot
);

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;

  assign w_op = i_instr[31:26];
  assign w_rs = i_instr[25:21];
  assign w_rt = i_instr[20:16];
  assign w_rd = i_instr[15:11];

  // Traits and masks by opcode; j/jal count as branches so they raise a bubble.
  always_comb begin
    o_slot       = '0;
    o_slot.pc    = i_pc;
    o_slot.instr = i_instr;
    case (w_op)
      6'h00: begin
        o_slot.rmask = reg_bit(w_rs) | reg_bit(w_rt);
        o_slot.wmask = reg_bit(w_rd);
      end
      6'h23: begin
        o_slot.rmask = reg_bit(w_rs);
        o_slot.wmask = reg_bit(w_rt);
        o_slot.is_lw = 1'b1;
      end
      6'h2b: begin
        o_slot.rmask = reg_bit(w_rs) | reg_bit(w_rt);
        o_slot.is_sw = 1'b1;
      end
      6'h04, 6'h05: begin
        o_slot.rmask     = reg_bit(w_rs) | reg_bit(w_rt);
        o_slot.is_branch = 1'b1;
      end
      6'h02: begin
        o_slot.is_branch = 1'b1;
        o_slot.is_jtype  = 1'b1;
      end
      6'h03: begin
        o_slot.wmask     = reg_bit(5'd31);
        o_slot.is_branch = 1'b1;
        o_slot.is_jtype  = 1'b1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        o_slot.rmask = reg_bit(w_rs);
        o_slot.wmask = reg_bit(w_rt);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/frontend_issue_window.sv
// N-entry fetch-to-decode issue window. Holds an age-ordered compacted array of
// pre-decoded slots and emits one per cycle, normally the oldest, optionally
// hoisting a younger dependency-free load or branch.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of frontend_issue_window_if (fetch in, decode out,
//                flush, pred_pc, hoisted, hoist_count)
module frontend_issue_window
  import frontend_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned LOOKAHEAD    = 3,
  parameter int unsigned ENABLE_HOIST = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  frontend_issue_window_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LA    = (LOOKAHEAD < DEPTH) ? LOOKAHEAD : DEPTH - 1;

  slot_t            r_slot     [DEPTH];
  slot_t            w_slot_nxt [DEPTH];
  slot_t            w_new;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_ins_pos;
  logic             r_bubble;
  logic [XLEN-1:0]  r_hoist_count;
  sel_rule_e        w_rule;
  logic [IDX_W-1:0] w_sel;
  logic             w_active;
  logic             w_emit;
  logic             w_drop;
  logic             w_fire;
  logic             w_remove;
  logic             w_in_ready;
  logic             w_in_fire;
  logic [XLEN-1:0]  w_pred_pc;

  fiw_entry_decode u_decode (
    .i_pc    (bus.in_pc),
    .i_instr (bus.in_instr),
    .o_slot  (w_new)
  );

  // Priority selector; acc_* are prefix-ORs over slots older than k.
  always_comb begin
    logic [MASK_W-1:0] acc_r;
    logic [MASK_W-1:0] acc_w;
    logic              acc_mem;
    logic              found;
    w_rule  = SEL_HEAD;
    w_sel   = '0;
    found   = 1'b0;
    acc_r   = r_slot[0].rmask;
    acc_w   = r_slot[0].wmask;
    acc_mem = r_slot[0].is_lw | r_slot[0].is_sw;
    if (r_slot[0].is_branch) begin
      w_rule = SEL_BRANCH_HEAD;
    end else if (r_slot[0].instr == '0) begin
      w_rule = SEL_DROP_NOP;
    end else if ((ENABLE_HOIST != 0) && (r_count > CNT_W'(1)) && r_slot[1].is_branch &&
                 !dep_any(r_slot[0].rmask, r_slot[0].wmask, r_slot[1].rmask, r_slot[1].wmask) &&
                 !(r_slot[0].is_lw && r_slot[1].is_jtype)) begin
      w_rule = SEL_HOIST_BR;
      w_sel  = IDX_W'(1);
    end else if (ENABLE_HOIST != 0) begin
      for (int unsigned k = 1; k <= LA; k++) begin
        if (!found && (CNT_W'(k) < r_count) && r_slot[IDX_W'(k)].is_lw && !acc_mem &&
            !dep_any(acc_r, acc_w, r_slot[IDX_W'(k)].rmask, r_slot[IDX_W'(k)].wmask)) begin
          found  = 1'b1;
          w_rule = SEL_HOIST_LW;
          w_sel  = IDX_W'(k);
        end
        acc_r   = acc_r | r_slot[IDX_W'(k)].rmask;
        acc_w   = acc_w | r_slot[IDX_W'(k)].wmask;
        acc_mem = acc_mem | r_slot[IDX_W'(k)].is_lw | r_slot[IDX_W'(k)].is_sw;
      end
    end
  end

  // Handshake qualifiers; flush blocks any removal or enqueue this cycle.
  assign w_active   = (r_count != '0) && !r_bubble;
  assign w_emit     = w_active && (w_rule != SEL_DROP_NOP);
  assign w_drop     = w_active && (w_rule == SEL_DROP_NOP);
  assign w_fire     = w_emit && bus.out_ready && !bus.flush;
  assign w_remove   = (w_fire || w_drop) && !bus.flush;
  assign w_in_ready = (r_count < CNT_W'(DEPTH)) && !bus.flush;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_ins_pos  = r_count - CNT_W'(w_remove);

  // Head after this emission or drop, falling back to the word being offered.
  always_comb begin
    w_pred_pc = '0;
    if (w_emit || w_drop) begin
      if (w_sel != '0)                w_pred_pc = r_slot[0].pc;
      else if (r_count > CNT_W'(1))   w_pred_pc = r_slot[1].pc;
      else if (bus.in_valid)          w_pred_pc = bus.in_pc;
    end else if (r_count != '0) begin
      w_pred_pc = r_slot[0].pc;
    end else if (bus.in_valid) begin
      w_pred_pc = bus.in_pc;
    end
  end

  // Compaction: slots at/after the removed one shift down, then the new entry lands.
  always_comb begin
    for (int j = 0; j < int'(DEPTH); j++) begin
      w_slot_nxt[j] = r_slot[j];
      if (w_remove && (IDX_W'(j) >= w_sel) && (j < int'(DEPTH) - 1))
        w_slot_nxt[j] = r_slot[IDX_W'(j + 1)];
      if (w_in_fire && (CNT_W'(j) == w_ins_pos))
        w_slot_nxt[j] = w_new;
    end
  end

  // Window state, bubble and saturating hoist counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count       <= '0;
      r_bubble      <= 1'b0;
      r_hoist_count <= '0;
      for (int j = 0; j < int'(DEPTH); j++) r_slot[j] <= '0;
    end else if (bus.flush) begin
      r_count  <= '0;
      r_bubble <= 1'b0;
    end else begin
      r_count  <= r_count + CNT_W'(w_in_fire) - CNT_W'(w_remove);
      r_bubble <= w_fire && ((w_rule == SEL_BRANCH_HEAD) || (w_rule == SEL_HOIST_BR));
      if (w_fire && (w_sel != '0) && (r_hoist_count != '1))
        r_hoist_count <= r_hoist_count + XLEN'(1);
      for (int j = 0; j < int'(DEPTH); j++) r_slot[j] <= w_slot_nxt[j];
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_emit;
  assign bus.pc          = w_emit ? r_slot[w_sel].pc : '0;
  assign bus.instr       = w_emit ? r_slot[w_sel].instr : '0;
  assign bus.hoisted     = w_emit && (w_sel != '0);
  assign bus.pred_pc     = w_pred_pc;
  assign bus.hoist_count = r_hoist_count;

endmodule
